serial_addsub_ovf: RTL
======================

Name: serial_addsub_ovf

Overview:
- Bit-serial two's-complement adder/subtractor. Produces the sum, the effective second operand and an overflow/valid flag for the existing combinational sign-rule validity checker.
- Processes one bit per clock from LSB to MSB, controlled by a start/done handshake.
- Sits between operand-entry logic (switches/registers) and display plus validity checking.
- Its outputs `A_q`, `Belp`, `S` are the operand/sum triple that the sign-rule checker consumes. Its own `val` must always agree with that checker.

Parameters:
- `WIDTH`, 4, operand/result width in bits (≥2).

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  request. Sampled only in IDLE or DONE.
- `sub`  in  1  0 = A+B, 1 = A−B. Latched with `start`.
- `A`  in  WIDTH  operand A, signed. Latched with `start`.
- `B`  in  WIDTH  operand B, signed. Latched with `start`.
- `busy`  out  1  high while bits are being computed.
- `done`  out  1  one-cycle pulse when the result is complete.
- `A_q`  out  WIDTH  latched A.
- `Belp`  out  WIDTH  effective B: B if `sub`=0, ~B if `sub`=1.
- `S`  out  WIDTH  sum register.
- `ovf`  out  1  signed overflow of the last operation.
- `val`  out  1  ~ovf (result valid).

Behaviour:
- One clock, `clk`. Reset `rst_n` is synchronous and active-low. No asynchronous paths.
- Reset values: state = IDLE, `busy`=0, `done`=0, `A_q`=0, `Belp`=0, `S`=0, bit index=0, carry=0, `ovf`=0, `val`=1.
- States: IDLE, RUN, DONE.
- IDLE: if `start`=1 at edge N:
  - latch `A_q`←A.
  - latch `Belp`←(`sub` ? ~B : B).
  - carry←`sub`, S←0, index←0.
  - go to RUN (`busy`=1 from N).
- RUN: on each edge, bit i of S ← A_q[i] ^ Belp[i] ^ carry; carry ← majority(A_q[i], Belp[i], carry); index increments.
  - On the edge processing i=WIDTH−1: `ovf` ← carry-in to MSB XOR carry-out of MSB; state → DONE; `busy`←0; `done`←1.
  - Bits are written at edges N+1 … N+WIDTH. `done` is high in the cycle after edge N+WIDTH, for exactly one cycle.
- DONE:
  - If `start`=1: behaves exactly as IDLE+start (back-to-back accepted, `done` drops).
  - Else: → IDLE, `done`←0.
- Outputs `A_q`, `Belp`, `S`, `ovf`, `val` hold their values until the next accepted `start`.
- `start`, `sub`, `A`, `B` are ignored while in RUN. Changes to the inputs mid-operation have no effect.
- Arithmetic is modulo 2^WIDTH. `ovf`=1 iff A_q[MSB]==Belp[MSB] and S[MSB]!=A_q[MSB]. Equivalently, `val` equals the sign-rule check on (A_q, Belp, S) for all inputs, including B=0 and B=most-negative under subtraction.
- Intermediate S bits are visible during RUN. Consumers use S only when `busy`=0.
- Reset asserted mid-RUN: all outputs return to reset values at that edge. No `done` pulse is issued.
- Reset has priority over `start` at the same edge.

Optional Feature:
- Macro `SERIAL_ADDSUB_SAT_EN`.
- Defined: on overflow, `S` is clamped when `done` asserts:
  - positive overflow (A_q[MSB]=0) → 0111…1.
  - negative overflow → 1000…0.
  - `ovf`/`val` still report the raw overflow (`ovf`=1, `val`=0).
  - With saturation, `val` is NOT required to match the sign-rule check on (A_q, Belp, S).
- Undefined: `S` is the wrapped modulo result. No clamp logic is present.

Test Plan:
- WIDTH=4, add 3+4 (A=0011, B=0100, `sub`=0), `start` at edge N → `busy` at N..N+3, `done` pulse after N+4; S=0111, Belp=0100, `ovf`=0, `val`=1.
- Add 5+4 → S=1001, `ovf`=1, `val`=0. With `SERIAL_ADDSUB_SAT_EN`: S=0111, `ovf`=1, `val`=0.
- Subtract 0−(−8) (A=0000, B=1000, `sub`=1) → Belp=0111, S=1000, `ovf`=1, `val`=0. Subtract −8−0 → Belp=1111, S=1000, `ovf`=0, `val`=1.
- Subtract 2−5 → Belp=1010, S=1101, `val`=1. Toggle A/B/`sub` and pulse `start` during RUN → result unchanged, no restart, single `done`.
- Start 7+1, assert `rst_n`=0 after 2 RUN edges → next cycle `busy`=0, S=0000, `val`=1, no `done`. Release reset, start 1+1 → S=0010 after `done`.
- Hold `start`=1 continuously with 1+1 then switch to 7+7 → each `done` pulse followed immediately by RUN; results 0010 then 1110 (`ovf`=1). Pulses are WIDTH+1 cycles apart.

Source files
------------

// File: rtl/serial_addsub_ovf_if.sv
// ============================================================================
// Module   : serial_addsub_ovf_if
// Purpose  : Request/result bundle for the bit-serial adder/subtractor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_addsub_ovf_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] A_q;
  logic [WIDTH-1:0] Belp;
  logic [WIDTH-1:0] S;
  logic             ovf;
  logic             val;

  modport master (
    output start, sub, A, B,
    input  busy, done, A_q, Belp, S, ovf, val
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, A_q, Belp, S, ovf, val
  );
endinterface

`default_nettype wire

// File: rtl/serial_addsub_ovf.sv
// ============================================================================
// Module   : serial_addsub_ovf
// Purpose  : Bit-serial two's-complement add/subtract, LSB first, with
//            signed overflow flag. Optional SERIAL_ADDSUB_SAT_EN clamps S.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_addsub_ovf #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_ovf_if.slave   bus
);

  localparam int                IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] belp_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_upd;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;
  logic             accept;
  logic             last_bit;
  logic             sum_bit;
  logic             carry_out;
  logic             bit_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) begin
          last_bit = 1'b1;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sum_bit   = a_q[idx_q] ^ belp_q[idx_q] ^ carry_q;
    carry_out = (a_q[idx_q] & belp_q[idx_q]) | (a_q[idx_q] & carry_q) |
                (belp_q[idx_q] & carry_q);
    // Only meaningful on the MSB step: carry-in differs from carry-out.
    bit_ovf   = carry_q ^ carry_out;
    s_upd     = s_q;
    s_upd[idx_q] = sum_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      belp_q  <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.A;
      belp_q  <= bus.sub ? ~bus.B : bus.B;
      carry_q <= bus.sub;
      s_q     <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      s_q     <= s_upd;
      carry_q <= carry_out;
      idx_q   <= idx_q + 1'b1;
      done_q  <= 1'b0;
      if (last_bit) begin
        idx_q  <= '0;
        ovf_q  <= bit_ovf;
        busy_q <= 1'b0;
        done_q <= 1'b1;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (bit_ovf) begin
          s_q <= a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.A_q  = a_q;
  assign bus.Belp = belp_q;
  assign bus.S    = s_q;
  assign bus.ovf  = ovf_q;
  assign bus.val  = ~ovf_q;

endmodule

`default_nettype wire
